// File: rtl/commit_trace_buffer_pkg.sv
// Shared constants and types for the commit trace buffer.
// Contains no logic, so it adds no latency and applies no backpressure.
// Holds the ebreak encoding, the entry width helper and the FSM state encodings.
package commit_trace_buffer_pkg;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

    // PC + instr + nextPC + 32-bit seq + drop flag
    function automatic int trace_entry_width(input int pc_w, input int instr_w);
        return 2 * pc_w + instr_w + 32 + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } trace_state_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// Generic first-word-fall-through FIFO that holds the storage, pointers and occupancy.
// Latency: a push in cycle N is visible at the head in cycle N+1.
// Backpressure: a push while full is refused unless a pop happens in the same cycle.
module trace_fifo_mem #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    output logic                     push_acc,
    input  logic                     pop_rdy,
    output logic                     head_vld,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          full;
    logic          pop_acc;

    assign full     = (cnt == CW'(DEPTH));
    assign pop_acc  = pop_rdy && (cnt != '0);
    // A slot freed by a same-cycle pop can be refilled immediately.
    assign push_acc = push_vld && (!full || pop_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_acc) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_vld = (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;

endmodule

// File: rtl/commit_trace_buffer.sv
// Buffers the CPU commit stream with sequence/drop tags and flags halt and commit starvation.
// Latency: a commit in cycle N appears on m_* in cycle N+1.
// Backpressure: never stalls the CPU; commits that arrive while full and not popping are dropped and counted.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 8,
    parameter int WDOG_LIMIT  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [PC_WIDTH-1:0]      commit_PC,
    input  logic [INSTR_WIDTH-1:0]   commit_Instr,
    input  logic [PC_WIDTH-1:0]      commit_nextPC,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [PC_WIDTH-1:0]      m_PC,
    output logic [INSTR_WIDTH-1:0]   m_Instr,
    output logic [PC_WIDTH-1:0]      m_nextPC,
    output logic [31:0]              m_seq,
    output logic                     m_drop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              overflow_cnt,
    output logic                     halt_detected,
    output logic                     wdog_timeout
);

    localparam int ENTRY_W = trace_entry_width(PC_WIDTH, INSTR_WIDTH);
    localparam int WW      = $clog2(WDOG_LIMIT);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    next_pc;
        logic [31:0]            seq;
        logic                   drop;
    } entry_t;

    entry_t       push_dat;
    entry_t       head_dat;
    logic         push_acc;
    logic         drop_now;
    logic [31:0]  seq_cnt;
    logic         drop_pending;
    logic [WW-1:0] wdog_cnt;
    trace_state_t state;

    assign push_dat = '{pc:      commit_PC,
                        instr:   commit_Instr,
                        next_pc: commit_nextPC,
                        seq:     seq_cnt,
                        drop:    drop_pending};

    trace_fifo_mem #(
        .W     (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (commit_valid),
        .push_dat (push_dat),
        .push_acc (push_acc),
        .pop_rdy  (m_ready),
        .head_vld (m_valid),
        .head_dat (head_dat),
        .count    (count)
    );

    assign m_PC     = head_dat.pc;
    assign m_Instr  = head_dat.instr;
    assign m_nextPC = head_dat.next_pc;
    assign m_seq    = head_dat.seq;
    assign m_drop   = head_dat.drop;

    assign drop_now = commit_valid && !push_acc;

    // Seq advances on every commit, so a gap in m_seq equals the number of drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_cnt      <= '0;
            drop_pending <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            if (commit_valid) begin
                seq_cnt <= seq_cnt + 32'd1;
            end
            if (push_acc) begin
                drop_pending <= 1'b0;
            end else if (drop_now) begin
                drop_pending <= 1'b1;
            end
            if (drop_now && overflow_cnt != 16'hFFFF) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

    // A commit always clears the watchdog, so halt and timeout never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            wdog_cnt      <= '0;
            halt_detected <= 1'b0;
            wdog_timeout  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (commit_valid) begin
                        wdog_cnt <= '0;
                        if (commit_Instr == INSTR_WIDTH'(EBREAK_INSTR)) begin
                            state         <= ST_HALTED;
                            halt_detected <= 1'b1;
                        end
                    end else if (wdog_cnt == WW'(WDOG_LIMIT - 1)) begin
                        state        <= ST_TIMEOUT;
                        wdog_timeout <= 1'b1;
                    end else begin
                        wdog_cnt <= wdog_cnt + WW'(1);
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with a queue-based scoreboard.
// Stimulus pushes expected entries; a negedge monitor compares every drained head entry.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_PC = '0;
    logic [31:0] commit_Instr = '0;
    logic [31:0] commit_nextPC = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_PC;
    logic [31:0] m_Instr;
    logic [31:0] m_nextPC;
    logic [31:0] m_seq;
    logic        m_drop;
    logic [3:0]  count;
    logic [15:0] overflow_cnt;
    logic        halt_detected;
    logic        wdog_timeout;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] npc;
        logic [31:0] seq;
        logic        drop;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    commit_trace_buffer #(
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32),
        .DEPTH       (8),
        .WDOG_LIMIT  (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .commit_valid  (commit_valid),
        .commit_PC     (commit_PC),
        .commit_Instr  (commit_Instr),
        .commit_nextPC (commit_nextPC),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_PC          (m_PC),
        .m_Instr       (m_Instr),
        .m_nextPC      (m_nextPC),
        .m_seq         (m_seq),
        .m_drop        (m_drop),
        .count         (count),
        .overflow_cnt  (overflow_cnt),
        .halt_detected (halt_detected),
        .wdog_timeout  (wdog_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    // Monitor: every handshake on the output port must match the queue head.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_entry got pc=%h seq=%0d drop=%0b", m_PC, m_seq, m_drop);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_PC !== mon_e.pc || m_Instr !== mon_e.instr || m_nextPC !== mon_e.npc ||
                    m_seq !== mon_e.seq || m_drop !== mon_e.drop) begin
                    failures++;
                    $display("FAIL entry got pc=%h instr=%h npc=%h seq=%0d drop=%0b expected pc=%h instr=%h npc=%h seq=%0d drop=%0b",
                             m_PC, m_Instr, m_nextPC, m_seq, m_drop,
                             mon_e.pc, mon_e.instr, mon_e.npc, mon_e.seq, mon_e.drop);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr,
                                input logic [31:0] npc, input logic [31:0] seq, input logic drop);
        exp_t e;
        e.pc = pc; e.instr = instr; e.npc = npc; e.seq = seq; e.drop = drop;
        exp_q.push_back(e);
    endtask

    // Drives one commit for exactly one clock edge; back-to-back calls give consecutive commits.
    task automatic commit(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] npc);
        commit_valid  = 1'b1;
        commit_PC     = pc;
        commit_Instr  = instr;
        commit_nextPC = npc;
        @(posedge clk);
        #1;
        commit_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        m_ready = 1'b1;
        for (int i = 0; i < 40 && count != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, {60'd0, count}, 64'd0);
        check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        idle(2);
        check("reset_m_valid", m_valid, 0);
        check("reset_count", count, 0);
        check("reset_m_PC", m_PC, 0);
        check("reset_m_seq", m_seq, 0);
        check("reset_overflow", overflow_cnt, 0);
        check("reset_halt", halt_detected, 0);
        check("reset_wdog", wdog_timeout, 0);
        do_reset();

        // Basic flow and halt detection
        m_ready = 1'b1;
        expect_entry(32'h8000_0000, 32'h0000_0413, 32'h8000_0004, 0, 1'b0);
        commit(32'h8000_0000, 32'h0000_0413, 32'h8000_0004);
        check("basic_m_valid_next_cycle", m_valid, 1);
        check("basic_halt_before", halt_detected, 0);
        expect_entry(32'h8000_0004, 32'h0010_0073, 32'h8000_0008, 1, 1'b0);
        commit(32'h8000_0004, 32'h0010_0073, 32'h8000_0008);
        check("basic_halt_after", halt_detected, 1);
        idle(1);
        check("basic_count_zero", count, 0);
        check("basic_sb_empty", 64'(exp_q.size()), 0);

        // Overflow, then full with simultaneous pop and push
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) expect_entry(32'h1000 + 32'(4 * i), 32'h13 + 32'(i), 32'h1004 + 32'(4 * i), 32'(i), 1'b0);
            commit(32'h1000 + 32'(4 * i), 32'h13 + 32'(i), 32'h1004 + 32'(4 * i));
        end
        check("ovf_count_full", count, 8);
        check("ovf_cnt_two", overflow_cnt, 2);
        check("ovf_m_seq_head", m_seq, 0);
        m_ready = 1'b1;
        expect_entry(32'h2000, 32'h0000_0093, 32'h2004, 10, 1'b1);
        commit(32'h2000, 32'h0000_0093, 32'h2004);
        check("full_poppush_count", count, 8);
        check("full_poppush_ovf", overflow_cnt, 2);
        drain("ovf_drain");

        // Watchdog
        do_reset();
        m_ready = 1'b1;
        expect_entry(32'h3000, 32'h0000_0013, 32'h3004, 0, 1'b0);
        commit(32'h3000, 32'h0000_0013, 32'h3004);
        idle(15);
        check("wdog_not_yet_15", wdog_timeout, 0);
        idle(1);
        check("wdog_at_16", wdog_timeout, 1);
        idle(4);
        check("wdog_sticky", wdog_timeout, 1);
        expect_entry(32'h3100, 32'h0000_0033, 32'h3104, 1, 1'b0);
        commit(32'h3100, 32'h0000_0033, 32'h3104);
        check("wdog_late_commit_buffered", m_valid, 1);
        check("wdog_no_halt", halt_detected, 0);
        drain("wdog_drain");
        check("wdog_still_set", wdog_timeout, 1);

        // Reset mid-operation
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) expect_entry(32'h4000 + 32'(4 * i), 32'h0000_0013, 32'h4004 + 32'(4 * i), 32'(i), 1'b0);
            commit(32'h4000 + 32'(4 * i), 32'h0000_0013, 32'h4004 + 32'(4 * i));
        end
        m_ready = 1'b1;
        idle(3);
        m_ready = 1'b0;
        check("midrst_count_before", count, 5);
        check("midrst_ovf_before", overflow_cnt, 3);
        do_reset();
        check("midrst_count", count, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_ovf", overflow_cnt, 0);
        m_ready = 1'b1;
        expect_entry(32'h5000, 32'h0000_0013, 32'h5004, 0, 1'b0);
        commit(32'h5000, 32'h0000_0013, 32'h5004);
        drain("midrst_drain");

        // Saturation of the drop counter
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_entry(32'h6000 + 32'(4 * i), 32'h0000_0013, 32'h6004 + 32'(4 * i), 32'(i), 1'b0);
            commit(32'h6000 + 32'(4 * i), 32'h0000_0013, 32'h6004 + 32'(4 * i));
        end
        for (int i = 0; i < 65540; i++) begin
            commit(32'h7000, 32'h0000_0013, 32'h7004);
            if (i == 65533) check("sat_ovf_fffe", overflow_cnt, 16'hFFFE);
            if (i == 65534) check("sat_ovf_ffff", overflow_cnt, 16'hFFFF);
        end
        check("sat_ovf_hold", overflow_cnt, 16'hFFFF);
        check("sat_count_full", count, 8);
        drain("sat_drain");
        expect_entry(32'h8000, 32'h0000_0013, 32'h8004, 32'd65548, 1'b1);
        commit(32'h8000, 32'h0000_0013, 32'h8004);
        drain("sat_final_drain");
        check("sat_ovf_final", overflow_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
